// File: rtl/multicycle_controller.sv
// multicycle_controller: control FSM for a multicycle RV32I core with instret counter and illegal-opcode flag
module multicycle_controller #(
  parameter int CNT_W        = 32,
  parameter bit ILLEGAL_HALT = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       op,
  input  logic [2:0]       funct3,
  input  logic             funct7b5,
  input  logic             Zero,
  output logic             PCWrite,
  output logic             AdrSrc,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             RegWrite,
  output logic [1:0]       ResultSrc,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ImmSrc,
  output logic [2:0]       ALUControl,
  output logic [CNT_W-1:0] instret,
  output logic             illegal,
  output logic [3:0]       state_dbg
);
  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
    EXECUTER, EXECUTEI, ALUWB, BRANCH, JAL, ILLEGAL
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_B   = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  state_t     state, next;
  logic [6:0] op_q;
  logic [2:0] funct3_q;
  logic       funct7b5_q;
  logic       pc_update, branch;
  logic [1:0] alu_op;
  logic [2:0] alu_dec;

  assign state_dbg = state;

  // State register, instruction-field latch, retire counter and sticky illegal flag
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= FETCH;
      op_q       <= '0;
      funct3_q   <= '0;
      funct7b5_q <= 1'b0;
      instret    <= '0;
      illegal    <= 1'b0;
    end else begin
      state <= next;
      if (IRWrite) begin
        op_q       <= op;
        funct3_q   <= funct3;
        funct7b5_q <= funct7b5;
      end
      if (state == ILLEGAL) illegal <= 1'b1;
      if (next == FETCH && (state == MEMWB || state == MEMWRITE || state == ALUWB || state == BRANCH))
        instret <= instret + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Next-state and control decode; everything is forced low while reset is asserted
  always_comb begin
    next      = state;
    pc_update = 1'b0;
    branch    = 1'b0;
    alu_op    = 2'b00;
    AdrSrc    = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    RegWrite  = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    case (state)
      FETCH: begin
        IRWrite   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        pc_update = 1'b1;
        next      = DECODE;
      end
      DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        next    = (op_q == OP_LW || op_q == OP_SW) ? MEMADR :
                  op_q == OP_R   ? EXECUTER :
                  op_q == OP_I   ? EXECUTEI :
                  op_q == OP_B   ? BRANCH   :
                  op_q == OP_JAL ? JAL      : ILLEGAL;
      end
      MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        next    = (op_q == OP_SW) ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        AdrSrc = 1'b1;
        next   = MEMWB;
      end
      MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
        next      = FETCH;
      end
      MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
        next     = FETCH;
      end
      EXECUTER: begin
        ALUSrcA = 2'b10;
        alu_op  = 2'b10;
        next    = ALUWB;
      end
      EXECUTEI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        alu_op  = 2'b10;
        next    = ALUWB;
      end
      ALUWB: begin
        RegWrite = 1'b1;
        next     = FETCH;
      end
      BRANCH: begin
        ALUSrcA = 2'b10;
        alu_op  = 2'b01;
        branch  = 1'b1;
        next    = FETCH;
      end
      JAL: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        pc_update = 1'b1;
        next      = ALUWB;
      end
      ILLEGAL: next = ILLEGAL_HALT ? ILLEGAL : FETCH;
      default: next = FETCH;
    endcase
    alu_dec    = funct3_q == 3'b000 ? ((op_q[5] & funct7b5_q) ? 3'b001 : 3'b000) :
                 funct3_q == 3'b010 ? 3'b101 :
                 funct3_q == 3'b110 ? 3'b011 :
                 funct3_q == 3'b111 ? 3'b010 : 3'b000;
    ALUControl = alu_op == 2'b01 ? 3'b001 : alu_op == 2'b10 ? alu_dec : 3'b000;
    ImmSrc     = op_q == OP_SW ? 2'b01 : op_q == OP_B ? 2'b10 : op_q == OP_JAL ? 2'b11 : 2'b00;
    PCWrite    = pc_update | (branch & (funct3_q == 3'b001 ? ~Zero : Zero));
    if (!reset) begin
      PCWrite    = 1'b0;
      AdrSrc     = 1'b0;
      MemWrite   = 1'b0;
      IRWrite    = 1'b0;
      RegWrite   = 1'b0;
      ResultSrc  = 2'b00;
      ALUSrcA    = 2'b00;
      ALUSrcB    = 2'b00;
      ImmSrc     = 2'b00;
      ALUControl = 3'b000;
    end
  end
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: randomized per-instruction checks of the controller against a cycle-table model
module tb_multicycle_controller;
  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
  localparam logic [6:0] IT = 7'b0010011, BR = 7'b1100011, JL = 7'b1101111;

  logic clk = 1'b0;
  logic rst1, rst2, zero, f7;
  logic [6:0] op;
  logic [2:0] f3;
  always #5 clk = ~clk;

  logic pcw1, adr1, mw1, irw1, rw1, ill1, pcw2, adr2, mw2, irw2, rw2, ill2;
  logic [1:0] rs1, sa1, sb1, is1, rs2, sa2, sb2, is2;
  logic [2:0] ac1, ac2;
  logic [31:0] cnt1;
  logic [3:0] cnt2, sd1, sd2;

  multicycle_controller #(.CNT_W(32), .ILLEGAL_HALT(1'b1)) dut1 (
    .clk(clk), .reset(rst1), .op(op), .funct3(f3), .funct7b5(f7), .Zero(zero),
    .PCWrite(pcw1), .AdrSrc(adr1), .MemWrite(mw1), .IRWrite(irw1), .RegWrite(rw1),
    .ResultSrc(rs1), .ALUSrcA(sa1), .ALUSrcB(sb1), .ImmSrc(is1), .ALUControl(ac1),
    .instret(cnt1), .illegal(ill1), .state_dbg(sd1));

  multicycle_controller #(.CNT_W(4), .ILLEGAL_HALT(1'b0)) dut2 (
    .clk(clk), .reset(rst2), .op(op), .funct3(f3), .funct7b5(f7), .Zero(zero),
    .PCWrite(pcw2), .AdrSrc(adr2), .MemWrite(mw2), .IRWrite(irw2), .RegWrite(rw2),
    .ResultSrc(rs2), .ALUSrcA(sa2), .ALUSrcB(sb2), .ImmSrc(is2), .ALUControl(ac2),
    .instret(cnt2), .illegal(ill2), .state_dbg(sd2));

  logic sel;
  logic [15:0] vec1, vec2, obs_vec;
  logic [31:0] obs_cnt, exp_cnt;
  logic obs_ill, exp_ill;
  logic [6:0] prev_op;
  int checks = 0, passed = 0;

  assign vec1    = {pcw1, adr1, mw1, irw1, rw1, rs1, sa1, sb1, is1, ac1};
  assign vec2    = {pcw2, adr2, mw2, irw2, rw2, rs2, sa2, sb2, is2, ac2};
  assign obs_vec = sel ? vec2 : vec1;
  assign obs_cnt = sel ? {28'b0, cnt2} : cnt1;
  assign obs_ill = sel ? ill2 : ill1;

  function automatic logic [15:0] mk(input logic pcw, adr, mw, irw, rw,
                                     input logic [1:0] rs, sa, sb, im, input logic [2:0] ac);
    return {pcw, adr, mw, irw, rw, rs, sa, sb, im, ac};
  endfunction

  // Expected controls for cycle c of instruction o; p is the previous instruction's opcode
  function automatic logic [15:0] exp_vec(input logic [6:0] o, p, input logic [2:0] ff3,
                                          input logic ff7, z, input int c);
    logic [6:0] io;
    logic [1:0] im;
    logic [2:0] dec;
    logic [15:0] wb;
    io  = (c == 0) ? p : o;
    im  = io == SW ? 2'd1 : io == BR ? 2'd2 : io == JL ? 2'd3 : 2'd0;
    case (ff3)
      3'b000:  dec = (o == RT && ff7) ? 3'd1 : 3'd0;
      3'b010:  dec = 3'd5;
      3'b110:  dec = 3'd3;
      3'b111:  dec = 3'd2;
      default: dec = 3'd0;
    endcase
    wb = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 2'd0, im, 3'd0);
    if (c == 0) return mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 2'd0, 2'd2, im, 3'd0);
    if (c == 1) return mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd1, 2'd1, im, 3'd0);
    case (o)
      LW: return c == 2 ? mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd2, 2'd1, im, 3'd0) :
                 c == 3 ? mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, im, 3'd0) :
                          mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 2'd0, 2'd0, im, 3'd0);
      SW: return c == 2 ? mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd2, 2'd1, im, 3'd0) :
                          mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, im, 3'd0);
      RT: return c == 2 ? mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd2, 2'd0, im, dec) : wb;
      IT: return c == 2 ? mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd2, 2'd1, im, dec) : wb;
      BR: return mk(ff3 == 3'b001 ? ~z : z, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd2, 2'd0, im, 3'd1);
      JL: return c == 2 ? mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd1, 2'd2, im, 3'd0) : wb;
      default: return 16'h0;
    endcase
  endfunction

  function automatic bit legal(input logic [6:0] o);
    return o == LW || o == SW || o == RT || o == IT || o == BR || o == JL;
  endfunction

  function automatic int lat(input logic [6:0] o);
    return o == LW ? 5 : (o == SW || o == RT || o == IT || o == JL) ? 4 : 3;
  endfunction

  // One instruction on the selected DUT; zf<0 randomizes Zero; abort_at>=0 asserts reset in that cycle
  task automatic run_instr(input string tag, input logic [6:0] o, input logic [2:0] ff3,
                           input logic ff7, input int zf, input int abort_at);
    logic [15:0] e;
    logic [31:0] ec;
    op = o; f3 = ff3; f7 = ff7;
    ec = sel ? (exp_cnt & 32'hF) : exp_cnt;
    for (int c = 0; c < lat(o); c++) begin
      @(negedge clk);
      zero = zf < 0 ? 1'($urandom_range(0, 1)) : (zf != 0);
      if (c == abort_at) begin
        if (sel) rst2 = 1'b0; else rst1 = 1'b0;
        #1;
        checks++;
        if (obs_vec !== 16'h0) $display("FAIL %s reset-strobes got=%h want=0000", tag, obs_vec);
        else passed++;
        @(posedge clk);
        #1;
        if (sel) rst2 = 1'b1; else rst1 = 1'b1;
        exp_cnt = 0; exp_ill = 1'b0; prev_op = 7'd0;
        return;
      end
      #1;
      e = exp_vec(o, prev_op, ff3, ff7, zero, c);
      checks++;
      if ({obs_vec, obs_ill, obs_cnt} !== {e, exp_ill, ec})
        $display("FAIL %s op=%b f3=%b c=%0d got vec=%h ill=%b cnt=%0d want vec=%h ill=%b cnt=%0d",
                 tag, o, ff3, c, obs_vec, obs_ill, obs_cnt, e, exp_ill, ec);
      else passed++;
      if (c == 1) begin op = 7'($urandom); f3 = 3'($urandom); f7 = 1'($urandom); end
    end
    prev_op = o;
    if (legal(o)) exp_cnt++; else exp_ill = 1'b1;
  endtask

  task automatic test_reset();
    sel = 1'b0; rst1 = 1'b0; rst2 = 1'b0; op = LW; f3 = 3'd0; f7 = 1'b0; zero = 1'b0;
    exp_cnt = 0; exp_ill = 1'b0; prev_op = 7'd0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      checks++;
      if ({vec1, ill1, cnt1, vec2, ill2, cnt2} !== 54'h0)
        $display("FAIL reset got vec1=%h ill1=%b cnt1=%0d vec2=%h ill2=%b cnt2=%0d want all 0",
                 vec1, ill1, cnt1, vec2, ill2, cnt2);
      else passed++;
    end
    @(posedge clk);
    #1 rst1 = 1'b1;
  endtask

  task automatic test_lw();
    run_instr("lw", LW, 3'b010, 1'b0, -1, -1);
    run_instr("lw2", LW, 3'($urandom), 1'($urandom), -1, -1);
  endtask

  task automatic test_sw();
    run_instr("sw", SW, 3'b010, 1'b0, -1, -1);
    run_instr("sw_after_sw", SW, 3'($urandom), 1'($urandom), -1, -1);
  endtask

  task automatic test_branch();
    for (int z = 0; z < 2; z++) begin
      run_instr("beq", BR, 3'b000, 1'($urandom), z, -1);
      run_instr("bne", BR, 3'b001, 1'($urandom), z, -1);
    end
  endtask

  task automatic test_alu();
    run_instr("r_sub", RT, 3'b000, 1'b1, -1, -1);
    run_instr("r_add", RT, 3'b000, 1'b0, -1, -1);
    run_instr("addi_b30", IT, 3'b000, 1'b1, -1, -1);
    run_instr("ori", IT, 3'b110, 1'($urandom), -1, -1);
    run_instr("andi", IT, 3'b111, 1'($urandom), -1, -1);
    run_instr("slti", IT, 3'b010, 1'($urandom), -1, -1);
    for (int i = 0; i < 10; i++)
      run_instr("alu_rand", ($urandom_range(0, 1) != 0) ? RT : IT, 3'($urandom), 1'($urandom), -1, -1);
  endtask

  task automatic test_jal();
    run_instr("jal", JL, 3'($urandom), 1'($urandom), -1, -1);
    run_instr("jal_then_lw", LW, 3'($urandom), 1'($urandom), -1, -1);
  endtask

  task automatic test_random();
    logic [6:0] ops [6];
    logic [6:0] o;
    ops = '{LW, SW, RT, IT, BR, JL};
    for (int i = 0; i < 30; i++) begin
      o = ops[$urandom_range(0, 5)];
      run_instr("random", o, o == BR ? 3'($urandom_range(0, 1)) : 3'($urandom), 1'($urandom), -1, -1);
    end
  endtask

  task automatic test_illegal_halt();
    logic [15:0] e;
    logic [31:0] ec;
    op = 7'b0110111; f3 = 3'($urandom); f7 = 1'($urandom);
    ec = exp_cnt;
    for (int c = 0; c < 22; c++) begin
      @(negedge clk);
      zero = 1'($urandom_range(0, 1));
      #1;
      e = exp_vec(7'b0110111, prev_op, f3, f7, zero, c);
      checks++;
      if ({vec1, ill1, cnt1} !== {e, c >= 3, ec})
        $display("FAIL illegal_halt c=%0d got vec=%h ill=%b cnt=%0d want vec=%h ill=%b cnt=%0d",
                 c, vec1, ill1, cnt1, e, c >= 3, ec);
      else passed++;
    end
    @(negedge clk);
    rst1 = 1'b0;
    #1;
    checks++;
    if (vec1 !== 16'h0) $display("FAIL illegal_reset_strobes got=%h want=0000", vec1);
    else passed++;
    @(posedge clk);
    #1 rst1 = 1'b1;
    exp_cnt = 0; exp_ill = 1'b0; prev_op = 7'd0;
    run_instr("after_illegal", IT, 3'b000, 1'b0, -1, -1);
  endtask

  task automatic test_reset_mid();
    run_instr("abort_lw", LW, 3'b010, 1'b0, -1, 3);
    run_instr("after_abort", IT, 3'b111, 1'b0, -1, -1);
    run_instr("after_abort_sw", SW, 3'b010, 1'b0, -1, -1);
  endtask

  task automatic test_wrap_and_skip();
    rst1 = 1'b0; sel = 1'b1;
    @(posedge clk);
    #1 rst2 = 1'b1;
    exp_cnt = 0; exp_ill = 1'b0; prev_op = 7'd0;
    for (int i = 0; i < 16; i++) run_instr("wrap_addi", IT, 3'($urandom), 1'($urandom), -1, -1);
    run_instr("skip_illegal", 7'b1110011, 3'($urandom), 1'($urandom), -1, -1);
    run_instr("after_skip", RT, 3'b000, 1'b1, -1, -1);
    @(negedge clk);
    #1;
    checks++;
    if (cnt2 !== exp_cnt[3:0]) $display("FAIL final_cnt got=%0d want=%0d", cnt2, exp_cnt[3:0]);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_lw();
    test_sw();
    test_branch();
    test_alu();
    test_jal();
    test_random();
    test_reset_mid();
    test_illegal_halt();
    test_wrap_and_skip();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
